// File: rtl/energy_avg_seq.sv
// Windowed energy averager: sums samples over a programmable window, then
// hands sum and count to an external divider and publishes the quotient.
module energy_avg_seq #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    input  logic [7:0]  window_len,
    output logic        div_init,
    output logic [15:0] div_A,
    output logic [15:0] div_B,
    input  logic [15:0] div_Result,
    input  logic        div_done,
    output logic [15:0] avg,
    output logic        avg_valid,
    output logic        busy,
    output logic        sat,
    output logic        drop,
    output logic        err
);

    localparam logic [1:0] S_ACCUM  = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    // Last WAIT count value on which a missing done becomes a timeout
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic [7:0]  len_q;
    logic [7:0]  tmo;

    logic        in_accum;
    logic        in_launch;
    logic        in_wait;
    logic [16:0] sum_ext;
    logic [15:0] sum_nxt;
    logic [7:0]  cnt_nxt;
    logic [7:0]  len_eff;
    logic        accept;
    logic        close;
    logic        tmo_hit;

    assign in_accum  = (state == S_ACCUM);
    assign in_launch = (state == S_LAUNCH);
    assign in_wait   = (state == S_WAIT);

    assign sum_ext = {1'b0, sum} + {1'b0, sample};
    assign sum_nxt = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
    assign cnt_nxt = cnt + 8'd1;

    // First sample of a window uses the live length; later ones the latched one
    always_comb begin
        len_eff = len_q;
        if (cnt == 8'd0) begin
            len_eff = (window_len == 8'd0) ? 8'd1 : window_len;
        end
    end

    assign accept  = in_accum && sample_valid;
    assign close   = accept && (cnt_nxt == len_eff);
    assign tmo_hit = (tmo == TMO_LAST);

    assign div_init = in_launch;
    assign busy     = in_launch | in_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACCUM;
            sum       <= 16'h0000;
            cnt       <= 8'h00;
            len_q     <= 8'h00;
            tmo       <= 8'h00;
            div_A     <= 16'h0000;
            div_B     <= 16'h0000;
            avg       <= 16'h0000;
            avg_valid <= 1'b0;
            sat       <= 1'b0;
            drop      <= 1'b0;
            err       <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            err       <= 1'b0;

            if (sample_valid && !in_accum) begin
                drop <= 1'b1;
            end

            unique case (1'b1)
                in_accum: begin
                    if (accept) begin
                        sum <= sum_nxt;
                        cnt <= cnt_nxt;
                        if (sum_ext[16]) begin
                            sat <= 1'b1;
                        end
                        if (cnt == 8'd0) begin
                            len_q <= len_eff;
                        end
                        if (close) begin
                            state <= S_LAUNCH;
                            div_A <= sum_nxt;
                            div_B <= {8'h00, cnt_nxt};
                        end
                    end
                end
                in_launch: begin
                    state <= S_WAIT;
                    tmo   <= 8'h00;
                end
                in_wait: begin
                    if (div_done) begin
                        avg       <= div_Result;
                        avg_valid <= 1'b1;
                        sum       <= 16'h0000;
                        cnt       <= 8'h00;
                        tmo       <= 8'h00;
                        state     <= S_ACCUM;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        sum   <= 16'h0000;
                        cnt   <= 8'h00;
                        tmo   <= 8'h00;
                        state <= S_ACCUM;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                default: begin
                    state <= S_ACCUM;
                    sum   <= 16'h0000;
                    cnt   <= 8'h00;
                    tmo   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_energy_avg_seq.sv
// Bench for energy_avg_seq: table windows, timeout, drop, reset-in-WAIT and
// random windows against an arithmetic window-average model.
module tb_energy_avg_seq;

    localparam int TMO = 64;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample;
    logic [7:0]  window_len;
    logic        div_init;
    logic [15:0] div_A;
    logic [15:0] div_B;
    logic [15:0] div_Result;
    logic        div_done;
    logic [15:0] avg;
    logic        avg_valid;
    logic        busy;
    logic        sat;
    logic        drop;
    logic        err;

    logic        model_done;
    logic [15:0] model_res;
    logic        man_done;
    logic [15:0] man_res;

    int          div_delay;
    bit          div_en;
    int          dcnt;
    bit          pend;
    logic [15:0] qa;
    logic [15:0] qb;

    int          n_chk;
    int          n_pass;
    bit          sat_exp;
    bit          drop_exp;
    logic [15:0] avg_exp;
    logic [15:0] smp [256];

    typedef struct {
        int          len;
        int          n;
        int          base;
        int          step;
        int          delay;
        logic [15:0] ex_a;
        logic [15:0] ex_b;
        logic [15:0] ex_avg;
    } win_t;

    win_t tbl [7];

    assign div_done   = model_done | man_done;
    assign div_Result = man_done ? man_res : model_res;

    energy_avg_seq #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .window_len   (window_len),
        .div_init     (div_init),
        .div_A        (div_A),
        .div_B        (div_B),
        .div_Result   (div_Result),
        .div_done     (div_done),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .busy         (busy),
        .sat          (sat),
        .drop         (drop),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: done pulse div_delay cycles after the init strobe
    always @(negedge clk) begin
        model_done = 1'b0;
        if (pend) begin
            if (dcnt <= 1) begin
                model_done = 1'b1;
                model_res  = (qb == 16'd0) ? 16'hFFFF : qa / qb;
                pend       = 1'b0;
            end else begin
                dcnt--;
            end
        end
        if (div_init && div_en) begin
            pend = 1'b1;
            dcnt = div_delay;
            qa   = div_A;
            qb   = div_B;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".div_init"}, 32'(div_init), 0);
        chk({nm, ".div_A"}, 32'(div_A), 0);
        chk({nm, ".div_B"}, 32'(div_B), 0);
        chk({nm, ".avg"}, 32'(avg), 0);
        chk({nm, ".avg_valid"}, 32'(avg_valid), 0);
        chk({nm, ".busy"}, 32'(busy), 0);
        chk({nm, ".sat"}, 32'(sat), 0);
        chk({nm, ".drop"}, 32'(drop), 0);
        chk({nm, ".err"}, 32'(err), 0);
    endtask

    // Caller sits at a negedge; returns at the negedge showing avg_valid/err
    task automatic run_window(input string nm, input int len, input int n,
                              input int delay, input int later_len,
                              input int inject_at, input int gap_max,
                              input logic [15:0] ex_a,
                              input logic [15:0] ex_b,
                              input logic [15:0] ex_avg);
        int k;
        int sumi;
        bit seen;
        bit errseen;
        bit bad_init;
        bit moved;
        sumi = 0;
        for (int i = 0; i < n; i++) sumi += int'(smp[i]);
        if (sumi > 65535) sat_exp = 1'b1;
        div_delay = delay;
        div_en    = (delay > 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_max > 0) begin
                int g;
                g = int'($urandom_range(gap_max, 0));
                repeat (g) begin
                    sample_valid = 1'b0;
                    window_len   = 8'($urandom);
                    @(negedge clk);
                end
            end
            sample_valid = 1'b1;
            sample       = smp[i];
            if (i == 0) window_len = 8'(len);
            else if (later_len < 0) window_len = 8'($urandom);
            else window_len = 8'(later_len);
            @(negedge clk);
            if (i == 0) begin
                chk({nm, ".prev_pulse_avg_valid"}, 32'(avg_valid), 0);
                chk({nm, ".prev_pulse_err"}, 32'(err), 0);
            end
        end
        sample_valid = 1'b0;
        chk({nm, ".div_init"}, 32'(div_init), 1);
        chk({nm, ".div_A"}, 32'(div_A), 32'(ex_a));
        chk({nm, ".div_B"}, 32'(div_B), 32'(ex_b));
        chk({nm, ".busy"}, 32'(busy), 1);
        k = 0;
        seen = 1'b0;
        errseen = 1'b0;
        bad_init = 1'b0;
        moved = 1'b0;
        while (!seen && !errseen && k < 400) begin
            @(negedge clk);
            k++;
            if (k == inject_at) begin
                sample_valid = 1'b1;
                sample       = 16'd1000;
                drop_exp     = 1'b1;
            end else begin
                sample_valid = 1'b0;
            end
            if (div_init) bad_init = 1'b1;
            if (div_A !== ex_a || div_B !== ex_b) moved = 1'b1;
            if (avg_valid) seen = 1'b1;
            if (err) errseen = 1'b1;
        end
        sample_valid = 1'b0;
        chk({nm, ".init_once"}, 32'(bad_init), 0);
        chk({nm, ".AB_held"}, 32'(moved), 0);
        if (delay > 0) begin
            chk({nm, ".avg_valid_seen"}, 32'(seen), 1);
            chk({nm, ".latency"}, 32'(k), 32'(delay + 1));
            chk({nm, ".avg"}, 32'(avg), 32'(ex_avg));
            chk({nm, ".no_err"}, 32'(errseen), 0);
            avg_exp = ex_avg;
        end else begin
            chk({nm, ".err_seen"}, 32'(errseen), 1);
            chk({nm, ".err_latency"}, 32'(k), 32'(TMO + 1));
            chk({nm, ".avg_kept"}, 32'(avg), 32'(avg_exp));
            chk({nm, ".no_avg_valid"}, 32'(seen), 0);
        end
        chk({nm, ".busy_after"}, 32'(busy), 0);
        chk({nm, ".sat"}, 32'(sat), 32'(sat_exp));
        chk({nm, ".drop"}, 32'(drop), 32'(drop_exp));
    endtask

    initial begin
        bit bad;
        n_chk = 0;
        n_pass = 0;
        sat_exp = 1'b0;
        drop_exp = 1'b0;
        avg_exp = 16'd0;
        div_en = 1'b0;
        div_delay = 1;
        pend = 1'b0;
        dcnt = 0;
        model_done = 1'b0;
        model_res = 16'd0;
        man_done = 1'b0;
        man_res = 16'd0;
        rst = 1'b1;
        sample_valid = 1'b0;
        sample = 16'd0;
        window_len = 8'd0;

        tbl[0] = '{7, 7, 5, 0, 17, 16'd35, 16'd7, 16'd5};
        tbl[1] = '{0, 1, 9, 0, 1, 16'd9, 16'd1, 16'd9};
        tbl[2] = '{4, 4, 100, 10, 2, 16'd460, 16'd4, 16'd115};
        tbl[3] = '{3, 3, 1000, 1, 64, 16'd3003, 16'd3, 16'd1001};
        tbl[4] = '{255, 255, 1, 0, 4, 16'd255, 16'd255, 16'd1};
        tbl[5] = '{1, 1, 65535, 0, 3, 16'hFFFF, 16'd1, 16'hFFFF};
        tbl[6] = '{2, 2, 16'hF000, 0, 3, 16'hFFFF, 16'd2, 16'h7FFF};

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                smp[i] = 16'(tbl[t].base + i * tbl[t].step);
            end
            run_window($sformatf("tbl%0d", t), tbl[t].len, tbl[t].n,
                       tbl[t].delay, -1, 0, 0,
                       tbl[t].ex_a, tbl[t].ex_b, tbl[t].ex_avg);
        end

        smp[0] = 16'd42;
        run_window("timeout", 1, 1, 0, -1, 0, 0, 16'd42, 16'd1, 16'd0);
        smp[0] = 16'd3;
        smp[1] = 16'd5;
        run_window("after_tmo", 2, 2, 2, -1, 0, 0, 16'd8, 16'd2, 16'd4);

        smp[0] = 16'd10;
        smp[1] = 16'd20;
        run_window("drop_win", 2, 2, 6, -1, 3, 0, 16'd30, 16'd2, 16'd15);
        for (int i = 0; i < 4; i++) smp[i] = 16'd7;
        run_window("len_change", 4, 4, 2, 3, 0, 0, 16'd28, 16'd4, 16'd7);

        for (int w = 0; w < 25; w++) begin
            int len;
            int eff;
            int sumi;
            int dly;
            int inj;
            logic [15:0] a;
            len = int'($urandom_range(6, 0));
            eff = (len == 0) ? 1 : len;
            sumi = 0;
            for (int i = 0; i < eff; i++) begin
                if ($urandom_range(3, 0) == 0)
                    smp[i] = 16'($urandom_range(65535, 30000));
                else
                    smp[i] = 16'($urandom_range(2000, 0));
                sumi += int'(smp[i]);
            end
            a = (sumi > 65535) ? 16'hFFFF : 16'(sumi);
            dly = int'($urandom_range(20, 1));
            inj = ($urandom_range(1, 0) == 1) ? int'($urandom_range(dly, 1)) : 0;
            run_window($sformatf("rnd%0d", w), len, eff, dly, -1, inj, 2,
                       a, 16'(eff), 16'(int'(a) / eff));
        end

        div_en = 1'b0;
        smp[0] = 16'd50;
        smp[1] = 16'd60;
        sample_valid = 1'b1;
        sample = smp[0];
        window_len = 8'd2;
        @(negedge clk);
        sample = smp[1];
        @(negedge clk);
        sample_valid = 1'b0;
        chk("rstwait.div_init", 32'(div_init), 1);
        repeat (5) @(negedge clk);
        chk("rstwait.busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_zero("rst_in_wait");
        @(negedge clk);
        rst = 1'b0;
        sat_exp = 1'b0;
        drop_exp = 1'b0;
        avg_exp = 16'd0;
        @(negedge clk);
        man_res = 16'd55;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (avg_valid || busy || err || div_init || avg != 16'd0) bad = 1'b1;
        end
        chk("late_done_ignored", 32'(bad), 0);
        check_zero("after_late_done");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
